// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if
//   Bundles every non-clock, non-reset signal of the trap sequencer.
//   master : EX stage / CSR array side (drives the event and CSR inputs,
//            receives the flush, redirect and CSR write strobes)
//   slave  : the trap sequencer itself
//   Inputs to the sequencer : stall, ex_valid, cmd_ecall_ex, cmd_mret_ex, pc_ex,
//                             irq_ext, mstatus_mie, csr_mtvec_ex, csr_mepc_ex
//   Outputs of the sequencer: trap_flush, trap_busy, jmp_valid, jmp_adr,
//                             mepc_we, mepc_wdata, mcause_we, mcause_wdata,
//                             mstatus_trap, mstatus_mret
interface trap_sequencer_if;
   logic        stall;
   logic        ex_valid;
   logic        cmd_ecall_ex;
   logic        cmd_mret_ex;
   logic [29:0] pc_ex;
   logic        irq_ext;
   logic        mstatus_mie;
   logic [29:0] csr_mtvec_ex;
   logic [29:0] csr_mepc_ex;
   logic        trap_flush;
   logic        trap_busy;
   logic        jmp_valid;
   logic [29:0] jmp_adr;
   logic        mepc_we;
   logic [29:0] mepc_wdata;
   logic        mcause_we;
   logic [31:0] mcause_wdata;
   logic        mstatus_trap;
   logic        mstatus_mret;

   modport master (
      output stall, ex_valid, cmd_ecall_ex, cmd_mret_ex, pc_ex,
             irq_ext, mstatus_mie, csr_mtvec_ex, csr_mepc_ex,
      input  trap_flush, trap_busy, jmp_valid, jmp_adr,
             mepc_we, mepc_wdata, mcause_we, mcause_wdata,
             mstatus_trap, mstatus_mret
   );

   modport slave (
      input  stall, ex_valid, cmd_ecall_ex, cmd_mret_ex, pc_ex,
             irq_ext, mstatus_mie, csr_mtvec_ex, csr_mepc_ex,
      output trap_flush, trap_busy, jmp_valid, jmp_adr,
             mepc_we, mepc_wdata, mcause_we, mcause_wdata,
             mstatus_trap, mstatus_mret
   );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Machine-mode trap/return sequencer between EX and the CSR array.
//   Accepts an external interrupt (if MIE), ECALL or MRET from EX, flushes
//   the pipeline for two cycles, then in one cycle issues the fetch redirect
//   (mtvec for traps, mepc for MRET) together with the CSR update strobes.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : trap_sequencer_if.slave (event inputs, CSR values, flush,
//             redirect and CSR write strobes)
module trap_sequencer #(
   parameter logic [31:0] MCAUSE_ECALL = 32'h0000_000B,
   parameter logic [31:0] MCAUSE_MEXT  = 32'h8000_000B
) (
   input logic             clk,
   input logic             rst_n,
   trap_sequencer_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_REDIR} state_t;
   typedef enum logic [1:0] {KIND_IRQ, KIND_ECALL, KIND_MRET} kind_t;

   state_t      state_reg, state_next;
   kind_t       kind_reg, kind_next;
   logic [29:0] epc_reg;
   logic [31:0] cause_reg, cause_next;

   logic irq_pend;
   logic event_any;
   logic accept;

   assign irq_pend  = bus.irq_ext & bus.mstatus_mie;
   assign event_any = irq_pend | bus.cmd_ecall_ex | bus.cmd_mret_ex;
   // rst_n gates the combinational flush so every output is 0 while in reset.
   assign accept    = rst_n & (state_reg == ST_IDLE) & ~bus.stall
                      & bus.ex_valid & event_any;

   // Interrupt beats ECALL beats MRET.
   always_comb begin
      kind_next  = KIND_MRET;
      cause_next = 32'h0;
      if (irq_pend) begin
         kind_next  = KIND_IRQ;
         cause_next = MCAUSE_MEXT;
      end else if (bus.cmd_ecall_ex) begin
         kind_next  = KIND_ECALL;
         cause_next = MCAUSE_ECALL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         kind_reg  <= KIND_IRQ;
         epc_reg   <= 30'h0;
         cause_reg <= 32'h0;
      end else begin
         state_reg <= state_next;
         // Captured fields only change on accept, so they hold through REDIR stalls.
         if (accept) begin
            kind_reg  <= kind_next;
            epc_reg   <= bus.pc_ex;
            cause_reg <= cause_next;
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      bus.trap_flush   = 1'b0;
      bus.trap_busy    = 1'b0;
      bus.jmp_valid    = 1'b0;
      bus.jmp_adr      = 30'h0;
      bus.mepc_we      = 1'b0;
      bus.mepc_wdata   = 30'h0;
      bus.mcause_we    = 1'b0;
      bus.mcause_wdata = 32'h0;
      bus.mstatus_trap = 1'b0;
      bus.mstatus_mret = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Flush in the accept cycle itself so the EX instruction commits nothing.
            if (accept) begin
               bus.trap_flush = 1'b1;
               state_next     = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            bus.trap_flush = 1'b1;
            bus.trap_busy  = 1'b1;
            state_next     = ST_REDIR;
         end
         ST_REDIR: begin
            bus.trap_busy = 1'b1;
            if (!bus.stall) begin
               bus.jmp_valid = 1'b1;
               state_next    = ST_IDLE;
               if (kind_reg == KIND_MRET) begin
                  bus.jmp_adr      = bus.csr_mepc_ex;
                  bus.mstatus_mret = 1'b1;
               end else begin
                  bus.jmp_adr      = bus.csr_mtvec_ex;
                  bus.mepc_we      = 1'b1;
                  bus.mepc_wdata   = epc_reg;
                  bus.mcause_we    = 1'b1;
                  bus.mcause_wdata = cause_reg;
                  bus.mstatus_trap = 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer
//   Directed scenarios from the trap/return behaviour plus a randomized run
//   checked against a transaction-level model of the sequencer.
module tb_trap_sequencer;

   localparam logic [31:0] C_ECALL = 32'h0000_000B;
   localparam logic [31:0] C_MEXT  = 32'h8000_000B;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   trap_sequencer_if bus ();

   trap_sequencer #(.MCAUSE_ECALL(C_ECALL), .MCAUSE_MEXT(C_MEXT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector layout:
   // {flush, busy, jmp_valid, jmp_adr, mepc_we, mepc_wdata, mcause_we, mcause_wdata, trap, mret}
   function automatic logic [98:0] pack(input logic fl, input logic bz, input logic jv,
                                        input logic [29:0] ja, input logic mw,
                                        input logic [29:0] md, input logic cw,
                                        input logic [31:0] cd, input logic st,
                                        input logic sm);
      return {fl, bz, jv, ja, mw, md, cw, cd, st, sm};
   endfunction

   function automatic logic [98:0] outs();
      return pack(bus.trap_flush, bus.trap_busy, bus.jmp_valid, bus.jmp_adr,
                  bus.mepc_we, bus.mepc_wdata, bus.mcause_we, bus.mcause_wdata,
                  bus.mstatus_trap, bus.mstatus_mret);
   endfunction

   task automatic set_in(input logic st, input logic ev, input logic ec, input logic mr,
                         input logic [29:0] pc, input logic irq, input logic mie);
      bus.stall        = st;
      bus.ex_valid     = ev;
      bus.cmd_ecall_ex = ec;
      bus.cmd_mret_ex  = mr;
      bus.pc_ex        = pc;
      bus.irq_ext      = irq;
      bus.mstatus_mie  = mie;
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled at
   // the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      logic [98:0] obs;
      rst_n = 1'b0;
      bus.csr_mtvec_ex = 30'h100;
      bus.csr_mepc_ex  = 30'h41;
      set_in(0, 1, 1, 0, 30'h40, 1, 1);
      #3;
      obs = outs();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 99'h0);
      end
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      #3;
      obs = outs();
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", obs, 99'h0);
      end
      next_cycle();
   endtask

   task automatic test_ecall();
      logic [98:0] obs, exp;
      bus.csr_mtvec_ex = 30'h100;
      set_in(0, 1, 1, 0, 30'h40, 0, 0);
      #3;
      obs = outs(); exp = pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checks++;
      if (obs !== exp) begin errors++; $display("FAIL ecall_T: got %h expected %h", obs, exp); end
      next_cycle();
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      #3;
      obs = outs(); exp = pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); checks++;
      if (obs !== exp) begin errors++; $display("FAIL ecall_T1: got %h expected %h", obs, exp); end
      next_cycle(); #3;
      obs = outs(); exp = pack(0, 1, 1, 30'h100, 1, 30'h40, 1, 32'hB, 1, 0); checks++;
      if (obs !== exp) begin errors++; $display("FAIL ecall_T2: got %h expected %h", obs, exp); end
      next_cycle(); #3;
      obs = outs(); checks++;
      if (obs !== '0) begin errors++; $display("FAIL ecall_T3: got %h expected %h", obs, 99'h0); end
      next_cycle();
   endtask

   task automatic test_mret();
      logic [98:0] obs, exp;
      bus.csr_mepc_ex = 30'h41;
      set_in(0, 1, 0, 1, 30'h7, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      next_cycle(); #3;
      obs = outs(); exp = pack(0, 1, 1, 30'h41, 0, 0, 0, 0, 0, 1); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mret_T2: got %h expected %h", obs, exp); end
      next_cycle();
   endtask

   task automatic test_irq_priority();
      logic [98:0] obs, exp;
      bus.csr_mtvec_ex = 30'h200;
      set_in(0, 1, 1, 1, 30'h80, 1, 1);
      next_cycle();
      // Interrupt line drops after accept; the trap must still complete.
      set_in(0, 0, 0, 0, 30'h0, 0, 1);
      next_cycle(); #3;
      obs = outs(); exp = pack(0, 1, 1, 30'h200, 1, 30'h80, 1, 32'h8000000B, 1, 0); checks++;
      if (obs !== exp) begin errors++; $display("FAIL irq_priority: got %h expected %h", obs, exp); end
      next_cycle();
   endtask

   task automatic test_no_accept();
      logic [98:0] obs;
      set_in(0, 1, 0, 0, 30'h10, 1, 0);
      #3;
      obs = outs(); checks++;
      if (obs !== '0) begin errors++; $display("FAIL irq_mie0: got %h expected %h", obs, 99'h0); end
      next_cycle();
      set_in(0, 0, 1, 0, 30'h10, 1, 1);
      #3;
      obs = outs(); checks++;
      if (obs !== '0) begin errors++; $display("FAIL ex_invalid: got %h expected %h", obs, 99'h0); end
      next_cycle();
      set_in(1, 1, 1, 0, 30'h10, 0, 0);
      #3;
      obs = outs(); checks++;
      if (obs !== '0) begin errors++; $display("FAIL stalled_ecall: got %h expected %h", obs, 99'h0); end
      next_cycle();
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      #3;
      obs = outs(); checks++;
      if (obs !== '0) begin errors++; $display("FAIL still_idle: got %h expected %h", obs, 99'h0); end
      next_cycle();
   endtask

   task automatic test_stall();
      logic [98:0] obs, exp;
      bus.csr_mtvec_ex = 30'h100;
      set_in(0, 1, 1, 0, 30'h44, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         // An ECALL sits in EX during REDIR; it must be ignored.
         set_in(1, 1, 1, 0, 30'h99, 0, 0);
         #3;
         obs = outs(); exp = pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); checks++;
         if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, exp); end
         next_cycle();
      end
      set_in(0, 1, 1, 0, 30'h99, 0, 0);
      #3;
      obs = outs(); exp = pack(0, 1, 1, 30'h100, 1, 30'h44, 1, 32'hB, 1, 0); checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_T5: got %h expected %h", obs, exp); end
      next_cycle();
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #3;
         obs = outs(); checks++;
         if (obs !== '0) begin errors++; $display("FAIL stall_after%0d: got %h expected %h", i, obs, 99'h0); end
         next_cycle();
      end
   endtask

   task automatic test_reset_flush();
      logic [98:0] obs;
      set_in(0, 1, 1, 0, 30'h50, 0, 0);
      next_cycle();
      #1;
      rst_n = 1'b0;
      #1;
      obs = outs(); checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_in_flush: got %h expected %h", obs, 99'h0); end
      next_cycle();
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         obs = outs(); checks++;
         if (obs !== '0) begin errors++; $display("FAIL reset_release%0d: got %h expected %h", i, obs, 99'h0); end
         next_cycle();
      end
   endtask

   // Model: an accepted event is a record; flush covers the accept cycle and
   // the next one, and the redirect lands on the first unstalled cycle from
   // two cycles after accept onward.
   task automatic test_random();
      logic [98:0] obs, exp;
      bit          act = 0;
      int          age = 0;
      bit          is_mret = 0;
      logic [29:0] m_epc = '0;
      logic [31:0] m_cause = '0;
      bit          acc, ipend;
      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                30'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
         bus.csr_mtvec_ex = 30'($urandom);
         bus.csr_mepc_ex  = 30'($urandom);
         ipend = bus.irq_ext && bus.mstatus_mie;
         acc   = !act && !bus.stall && bus.ex_valid &&
                 (ipend || bus.cmd_ecall_ex || bus.cmd_mret_ex);
         exp = '0;
         if (acc)
            exp = pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (act && age == 1)
            exp = pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (act && bus.stall)
            exp = pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (act && is_mret)
            exp = pack(0, 1, 1, bus.csr_mepc_ex, 0, 0, 0, 0, 0, 1);
         else if (act)
            exp = pack(0, 1, 1, bus.csr_mtvec_ex, 1, m_epc, 1, m_cause, 1, 0);
         #3;
         obs = outs(); checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random_cycle%0d: got %h expected %h", n, obs, exp);
         end
         if (acc) begin
            act     = 1;
            age     = 1;
            is_mret = !ipend && !bus.cmd_ecall_ex;
            m_epc   = bus.pc_ex;
            m_cause = ipend ? C_MEXT : C_ECALL;
         end else if (act && age == 1) begin
            age = 2;
         end else if (act && !bus.stall) begin
            act = 0;
         end
         next_cycle();
      end
      set_in(0, 0, 0, 0, 30'h0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_mret();
      test_irq_priority();
      test_no_accept();
      test_stall();
      test_reset_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap and return sequencer between the EX stage and the control/status register array. It accepts ECALL, MRET and a level-sensitive external interrupt from EX and flushes the pipeline. It generates the mepc/mcause/mstatus update strobes, then redirects fetch to mtvec (trap) or mepc (return). The block is a three-state FSM with captured cause/PC registers and a one-cycle redirect handshake held through stalls.

## Interface
- Parameters:
  - MCAUSE_ECALL, default 32'h0000_000B, cause code written for ECALL from M-mode
  - MCAUSE_MEXT, default 32'h8000_000B, cause code written for a machine external interrupt
- Ports:
  - clk  in  1  clock
  - rst_n  in  1  reset, asynchronous, active-low
  - stall  in  1  pipeline stall; while high, no event is accepted and REDIR holds
  - ex_valid  in  1  EX holds a real (non-bubble) instruction
  - cmd_ecall_ex  in  1  EX instruction is ECALL
  - cmd_mret_ex  in  1  EX instruction is MRET
  - pc_ex  in  30  EX instruction PC[31:2]
  - irq_ext  in  1  external interrupt request, level
  - mstatus_mie  in  1  mstatus.MIE, global interrupt enable
  - csr_mtvec_ex  in  30  mtvec[31:2] (direct mode only)
  - csr_mepc_ex  in  30  mepc[31:2]
  - trap_flush  out  1  kill EX result and all younger stages
  - trap_busy  out  1  FSM not idle; fetch holds
  - jmp_valid  out  1  fetch redirect strobe
  - jmp_adr  out  30  redirect target PC[31:2]
  - mepc_we  out  1  mepc write strobe
  - mepc_wdata  out  30  mepc value [31:2]
  - mcause_we  out  1  mcause write strobe
  - mcause_wdata  out  32  mcause value
  - mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0
  - mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1

## Operation
- States:
  - IDLE: ready to accept an event.
  - FLUSH: pipeline drain; stays exactly one cycle.
  - REDIR: issues the redirect and the CSR strobes.
  - Reset and default state are IDLE.
- Accept condition, in IDLE with ~stall & ex_valid:
  - irq_pend = irq_ext & mstatus_mie.
  - Priority: irq_pend > cmd_ecall_ex > cmd_mret_ex.
  - With no event, the FSM stays in IDLE.
- On accept:
  - Capture kind_q (IRQ/ECALL/MRET), epc_q = pc_ex, and cause_q = MCAUSE_MEXT (IRQ) or MCAUSE_ECALL (ECALL).
  - Go to FLUSH.
- IRQ: the EX instruction is not executed; epc_q is its PC, so it re-executes after return.
- ECALL: epc_q is the ECALL's own PC; software adds 4.
- FLUSH -> REDIR unconditionally.
- In REDIR while ~stall:
  - jmp_valid=1.
  - jmp_adr = csr_mtvec_ex (IRQ/ECALL) or csr_mepc_ex (MRET), sampled in this cycle.
  - IRQ/ECALL: mepc_we=1, mepc_wdata=epc_q, mcause_we=1, mcause_wdata=cause_q, mstatus_trap=1.
  - MRET: mstatus_mret=1; no mepc/mcause write.
  - Next state is IDLE.
- In REDIR with stall: hold REDIR, all strobes 0, captured registers unchanged.
- Events presented while not IDLE are ignored; they are in the flushed shadow.
- irq_ext deasserting after accept does not cancel the trap.

## Timing
- Reset values: all outputs 0; jmp_adr, mepc_wdata and mcause_wdata are 0; state IDLE.
- Accept cycle T: trap_flush=1 combinationally, so the EX instruction in T commits nothing (including its own CSR write).
- T+1 (FLUSH): trap_flush=1, trap_busy=1.
- T+2 (REDIR, no stall): trap_busy=1 and all strobes pulse for exactly one cycle. trap_flush=0.
- T+3: IDLE. Earliest next accept is T+3.
- Minimum event-to-redirect latency is 2 cycles. Each stall cycle in REDIR adds 1 cycle.
- Strobes are single-cycle and never repeat for one event.
- rst_n assertion in any state returns to IDLE immediately. No partial CSR write is issued; a pulse already sent stays completed.
- mtvec[1:0] and mepc[1:0] are not used; targets are word-aligned.

## Test plan
- ECALL at pc_ex=30'h40, mtvec=30'h100, no stall -> trap_flush at T and T+1. At T+2: jmp_valid, jmp_adr=30'h100, mepc_wdata=30'h40, mcause_wdata=32'hB, mstatus_trap=1. IDLE at T+3.
- MRET with mepc=30'h41 -> at T+2: jmp_adr=30'h41, mstatus_mret=1, mepc_we=0, mcause_we=0.
- irq_ext=1 with MIE=1, simultaneous with ECALL at pc_ex=30'h80 -> IRQ wins: mcause_wdata=32'h8000000B, mepc_wdata=30'h80.
- irq_ext=1 with MIE=0, or with ex_valid=0 -> no accept, trap_flush=0, state stays IDLE.
- stall=1 for 3 cycles in REDIR -> no strobes while stalled. A single jmp_valid at T+5. An ECALL presented during REDIR is ignored.
- rst_n low during FLUSH -> all outputs 0 immediately. After release, no jmp_valid and no CSR strobe occurs.
